// File: rtl/reg_file_ctl_if.sv
// Bus bundle for reg_file_ctl: decode read ports, writeback/load write ports,
// clear request and the sequencer status outputs.
interface reg_file_ctl_if #(
  parameter int W = 8,
  parameter int D = 4
);
  logic [D-1:0] srcA, srcB;
  logic         RegWrite;
  logic [D-1:0] writeReg;
  logic [W-1:0] writeValue;
  logic         LdWrite;
  logic [D-1:0] ldReg;
  logic [W-1:0] ldValue;
  logic         ClearReq;
  logic [W-1:0] ReadA, ReadB;
  logic         Busy;
  logic         ClearDone;

  modport master (
    output srcA, srcB, RegWrite, writeReg, writeValue,
           LdWrite, ldReg, ldValue, ClearReq,
    input  ReadA, ReadB, Busy, ClearDone
  );

  modport slave (
    input  srcA, srcB, RegWrite, writeReg, writeValue,
           LdWrite, ldReg, ldValue, ClearReq,
    output ReadA, ReadB, Busy, ClearDone
  );
endinterface

// File: rtl/reg_file_ctl.sv
// Dual-write-port register file with zero/protected entries, optional
// write-to-read bypass and a one-entry-per-cycle clear sequencer.
module reg_file_ctl #(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int ZERO_REG = 2**D-1,
  parameter int PROT_REG = 2**D-2,
  parameter int BYPASS   = 1
) (
  input  logic           CLK,
  input  logic           Reset,
  reg_file_ctl_if.slave  bus
);
  localparam int          N    = 2**D;
  localparam logic [D-1:0] ZR  = D'(ZERO_REG);
  localparam logic [D-1:0] PR  = D'(PROT_REG);
  localparam logic [D:0]   LAST = (D+1)'(N-1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                  state_q, state_d;
  logic [D:0]              cnt_q, cnt_d;
  logic [N-1:0][W-1:0]     mem_q, mem_d;
  logic                    wr0_ok, wr1_ok;

  assign wr0_ok = bus.RegWrite && (state_q == IDLE) &&
                  (bus.writeReg != ZR) && (bus.writeReg != PR);
  assign wr1_ok = bus.LdWrite && (state_q == IDLE) &&
                  (bus.ldReg != ZR) && (bus.ldReg != PR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    // port 1 first so port 0 overrides on an address collision
    if (wr1_ok) mem_d[bus.ldReg]    = bus.ldValue;
    if (wr0_ok) mem_d[bus.writeReg] = bus.writeValue;
    case (state_q)
      IDLE: if (bus.ClearReq) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: begin
        mem_d[cnt_q[D-1:0]] = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    bus.ReadA = mem_q[bus.srcA];
    if (BYPASS != 0 && wr1_ok && bus.ldReg == bus.srcA)    bus.ReadA = bus.ldValue;
    if (BYPASS != 0 && wr0_ok && bus.writeReg == bus.srcA) bus.ReadA = bus.writeValue;
    if (bus.srcA == ZR) bus.ReadA = '0;
  end

  always_comb begin
    bus.ReadB = mem_q[bus.srcB];
    if (BYPASS != 0 && wr1_ok && bus.ldReg == bus.srcB)    bus.ReadB = bus.ldValue;
    if (BYPASS != 0 && wr0_ok && bus.writeReg == bus.srcB) bus.ReadB = bus.writeValue;
    if (bus.srcB == ZR) bus.ReadB = '0;
  end

  assign bus.Busy      = (state_q != IDLE);
  assign bus.ClearDone = (state_q == DONE);
endmodule

// File: tb/tb_reg_file_ctl.sv
// Directed bench for reg_file_ctl: one bypassing and one non-bypassing
// instance share the same stimulus.
module tb_reg_file_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reg_file_ctl_if #(.W(8), .D(4)) bus0 ();
  reg_file_ctl_if #(.W(8), .D(4)) bus1 ();

  assign bus1.srcA       = bus0.srcA;
  assign bus1.srcB       = bus0.srcB;
  assign bus1.RegWrite   = bus0.RegWrite;
  assign bus1.writeReg   = bus0.writeReg;
  assign bus1.writeValue = bus0.writeValue;
  assign bus1.LdWrite    = bus0.LdWrite;
  assign bus1.ldReg      = bus0.ldReg;
  assign bus1.ldValue    = bus0.ldValue;
  assign bus1.ClearReq   = bus0.ClearReq;

  reg_file_ctl #(.W(8), .D(4), .BYPASS(1)) u_byp (.CLK(clk), .Reset(rst), .bus(bus0));
  reg_file_ctl #(.W(8), .D(4), .BYPASS(0)) u_nob (.CLK(clk), .Reset(rst), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [3:0] a, input logic [7:0] v);
    bus0.RegWrite = 1'b1; bus0.writeReg = a; bus0.writeValue = v;
    tick();
    bus0.RegWrite = 1'b0;
  endtask

  int busy_cnt, done_cnt, done_idx;

  initial begin
    bus0.srcA = '0; bus0.srcB = '0;
    bus0.RegWrite = 1'b0; bus0.writeReg = '0; bus0.writeValue = '0;
    bus0.LdWrite = 1'b0; bus0.ldReg = '0; bus0.ldValue = '0;
    bus0.ClearReq = 1'b0;
    #2;
    chk("reset_readA", 32'(bus0.ReadA), 32'h0);
    chk("reset_busy", 32'(bus0.Busy), 32'h0);
    chk("reset_done", 32'(bus0.ClearDone), 32'h0);
    #20 rst = 1'b0;
    tick();

    // write + same-cycle read
    bus0.RegWrite = 1'b1; bus0.writeReg = 4'd2; bus0.writeValue = 8'hA5; bus0.srcA = 4'd2;
    #1;
    chk("bypass_rd", 32'(bus0.ReadA), 32'hA5);
    chk("nobypass_rd_old", 32'(bus1.ReadA), 32'h00);
    tick();
    bus0.RegWrite = 1'b0;
    #1;
    chk("nobypass_rd_new", 32'(bus1.ReadA), 32'hA5);

    // async reset mid-run
    wr0(4'd3, 8'h5A);
    bus0.srcA = 4'd3; bus0.srcB = 4'd2;
    #1;
    chk("r3_before_rst", 32'(bus1.ReadA), 32'h5A);
    rst = 1'b1;
    #1;
    chk("r3_after_rst", 32'(bus0.ReadA), 32'h0);
    chk("r2_after_rst", 32'(bus1.ReadB), 32'h0);
    chk("busy_after_rst", 32'(bus0.Busy), 32'h0);
    rst = 1'b0;
    tick();

    // dual-port same address: port 0 wins
    bus0.RegWrite = 1'b1; bus0.writeReg = 4'd4; bus0.writeValue = 8'h11;
    bus0.LdWrite = 1'b1;  bus0.ldReg = 4'd4;    bus0.ldValue = 8'h22;
    bus0.srcA = 4'd4;
    #1;
    chk("conflict_bypass", 32'(bus0.ReadA), 32'h11);
    tick();
    // dual-port different addresses
    bus0.writeReg = 4'd6; bus0.writeValue = 8'h44;
    bus0.ldReg = 4'd5;    bus0.ldValue = 8'h33;
    #1;
    chk("conflict_stored", 32'(bus1.ReadA), 32'h11);
    bus0.srcA = 4'd5; bus0.srcB = 4'd6;
    #1;
    chk("ld_bypass", 32'(bus0.ReadA), 32'h33);
    chk("wb_bypass", 32'(bus0.ReadB), 32'h44);
    tick();
    bus0.RegWrite = 1'b0; bus0.LdWrite = 1'b0;
    #1;
    chk("ld_stored", 32'(bus1.ReadA), 32'h33);
    chk("wb_stored", 32'(bus1.ReadB), 32'h44);

    // zero and protected registers, both ports
    bus0.RegWrite = 1'b1; bus0.writeReg = 4'd15; bus0.writeValue = 8'hFF;
    bus0.LdWrite = 1'b1;  bus0.ldReg = 4'd14;    bus0.ldValue = 8'hFF;
    bus0.srcA = 4'd15; bus0.srcB = 4'd14;
    #1;
    chk("zero_no_bypass", 32'(bus0.ReadA), 32'h0);
    chk("prot_no_bypass", 32'(bus0.ReadB), 32'h0);
    tick();
    bus0.writeReg = 4'd14; bus0.ldReg = 4'd15;
    #1;
    chk("prot_no_bypass_p0", 32'(bus0.ReadB), 32'h0);
    chk("zero_no_bypass_p1", 32'(bus0.ReadA), 32'h0);
    tick();
    bus0.RegWrite = 1'b0; bus0.LdWrite = 1'b0;
    #1;
    chk("zero_stored", 32'(bus1.ReadA), 32'h0);
    chk("prot_stored", 32'(bus1.ReadB), 32'h0);

    // clear sequence
    for (int i = 0; i < 14; i++) wr0(4'(i), 8'(8'h10 + i));
    bus0.srcA = 4'd13;
    #1;
    chk("fill_r13", 32'(bus1.ReadA), 32'h1D);
    bus0.ClearReq = 1'b1;
    tick();
    bus0.ClearReq = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_idx = -1;
    bus0.srcA = 4'd1;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) begin
        bus0.RegWrite = 1'b1; bus0.writeReg = 4'd1; bus0.writeValue = 8'h77;
      end
      #1;
      if (i == 0) chk("busy_first", 32'(bus0.Busy), 32'h1);
      if (i == 2) chk("busy_write_no_bypass", 32'(bus0.ReadA), 32'h0);
      if (bus0.Busy) busy_cnt++;
      if (bus0.ClearDone) begin done_cnt++; done_idx = i; end
      tick();
      bus0.RegWrite = 1'b0;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd17);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_index", 32'(done_idx), 32'd16);
    chk("busy_end", 32'(bus0.Busy), 32'h0);
    for (int i = 0; i < 16; i++) begin
      bus0.srcA = 4'(i); bus0.srcB = 4'(i);
      #1;
      chk($sformatf("cleared_r%0d", i), 32'(bus1.ReadA), 32'h0);
    end
    tick();

    // reset during clear
    for (int i = 0; i < 4; i++) wr0(4'(i), 8'(8'hC0 + i));
    bus0.ClearReq = 1'b1;
    tick();
    bus0.ClearReq = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("busy_mid_clear", 32'(bus0.Busy), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("busy_rst_clear", 32'(bus0.Busy), 32'h0);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus0.ClearDone) done_cnt++;
    end
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);
    bus0.srcA = 4'd3; bus0.srcB = 4'd6;
    #1;
    chk("r3_zero_after_rst", 32'(bus1.ReadA), 32'h0);
    chk("r6_zero_after_rst", 32'(bus1.ReadB), 32'h0);

    // writes accepted again once idle
    wr0(4'd7, 8'h09);
    bus0.srcA = 4'd7;
    #1;
    chk("write_after_rst", 32'(bus1.ReadA), 32'h09);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
